// File: rtl/lcd_char_receiver.sv
// lcd_char_receiver: responder side of an HD44780-style character LCD bus.
// Decodes instruction/data writes into a 2x16 DDRAM shadow, answers status
// and data reads, and exposes a registered side read port for the display.
module lcd_char_receiver #(
    parameter int BUSY_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic [7:0] LCD_DATA,
    output logic [7:0] LCD_DOUT,
    output logic       LCD_DOE,
    output logic       BUSY,
    output logic       OVERRUN,
    output logic       DISP_ON,
    output logic       LINES2,
    input  logic       RD_LINE,
    input  logic [3:0] RD_COL,
    output logic [7:0] RD_CHAR
);

    // Counter must hold both the 32-entry clear sweep and the exec countdown.
    localparam int CW = (BUSY_CYCLES > 32) ? $clog2(BUSY_CYCLES) + 1 : 6;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEAR} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;

    logic       e_cur, e_prev;
    logic       rise, fall;
    logic       cap_rs, cap_rw;
    logic [7:0] cap_data;
    logic [4:0] ac;          // {line, col}
    logic       inc;
    logic       rd_ok;       // data read at the rise was served, so advance AC at the fall
    logic [7:0] mem [32];

    logic wr_ok, is_clr, is_nop;

    assign rise   = e_cur & ~e_prev;
    assign fall   = ~e_cur & e_prev;
    assign wr_ok  = fall & ~cap_rw & ~BUSY;
    assign is_clr = ~cap_rs & (cap_data == 8'h01);
    assign is_nop = ~cap_rs & (cap_data == 8'h00);

    // One AC step with line wrap; in 1-line mode the line bit stays 0.
    function automatic logic [4:0] ac_step(input logic [4:0] a, input logic up, input logic two);
        logic [4:0] r;
        r = a;
        if (up) begin
            if (a[3:0] == 4'hF) r = {two & ~a[4], 4'h0};
            else                r = {two & a[4], a[3:0] + 4'd1};
        end else begin
            if (a[3:0] == 4'h0) r = {two & ~a[4], 4'hF};
            else                r = {two & a[4], a[3:0] - 4'd1};
        end
        return r;
    endfunction

    // Register the enable strobe and keep one cycle of history for edge detect.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            e_cur  <= 1'b0;
            e_prev <= 1'b0;
        end else begin
            e_cur  <= LCD_E;
            e_prev <= e_cur;
        end
    end

    // Capture the bus qualifiers on the rise; they are acted on at the fall.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cap_rs   <= 1'b0;
            cap_rw   <= 1'b0;
            cap_data <= 8'h00;
        end else if (rise) begin
            cap_rs   <= LCD_RS;
            cap_rw   <= LCD_RW;
            cap_data <= LCD_DATA;
        end
    end

    // FSM state register; reset always restarts the full clear.
    always_ff @(posedge CLK) begin
        if (RESET) state <= S_CLEAR;
        else       state <= state_nx;
    end

    // FSM next-state: accepted writes start exec or clear, counters end them.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (wr_ok && !is_nop) state_nx = is_clr ? S_CLEAR : S_EXEC;
            S_EXEC:  if (cnt == '0) state_nx = S_IDLE;
            S_CLEAR: if (cnt == CW'(31)) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // FSM outputs: busy whenever not idle.
    always_comb begin
        BUSY = (state != S_IDLE);
    end

    // Exec countdown / clear sweep index.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt <= '0;
        end else begin
            case (state)
                S_IDLE:  cnt <= (state_nx == S_EXEC) ? CW'(BUSY_CYCLES - 1) : '0;
                S_EXEC:  cnt <= cnt - CW'(1);
                S_CLEAR: cnt <= cnt + CW'(1);
                default: cnt <= '0;
            endcase
        end
    end

    // Bus read responses, instruction decode, AC and mode flags.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            DISP_ON  <= 1'b0;
            LINES2   <= 1'b0;
            inc      <= 1'b1;
            ac       <= 5'd0;
            OVERRUN  <= 1'b0;
            LCD_DOUT <= 8'h00;
            LCD_DOE  <= 1'b0;
            rd_ok    <= 1'b0;
        end else begin
            if (rise && LCD_RW) begin
                LCD_DOE <= 1'b1;
                rd_ok   <= LCD_RS & ~BUSY;
                if (!LCD_RS) begin
                    LCD_DOUT <= {BUSY, ac[4], 2'b00, ac[3:0]};
                    OVERRUN  <= 1'b0;
                end else if (!BUSY) begin
                    LCD_DOUT <= mem[ac];
                end else begin
                    LCD_DOUT <= 8'h00;
                    OVERRUN  <= 1'b1;
                end
            end
            if (fall) begin
                LCD_DOE <= 1'b0;
                if (cap_rw) begin
                    if (cap_rs && rd_ok) ac <= ac_step(ac, inc, LINES2);
                end else if (BUSY) begin
                    OVERRUN <= 1'b1;
                end else if (cap_rs) begin
                    ac <= ac_step(ac, inc, LINES2);
                end else begin
                    casez (cap_data)
                        8'b1???????: ac <= {cap_data[6] & LINES2, cap_data[3:0]};
                        8'b01??????: ;
                        8'b001?????: begin
                            LINES2 <= cap_data[3];
                            if (!cap_data[3]) ac[4] <= 1'b0;
                        end
                        8'b0001????: if (!cap_data[3]) ac <= ac_step(ac, cap_data[2], LINES2);
                        8'b00001???: DISP_ON <= cap_data[2];
                        8'b000001??: inc <= cap_data[1];
                        8'b0000001?: ac <= 5'd0;
                        8'b00000001: begin
                            ac  <= 5'd0;
                            inc <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // DDRAM: clear sweep fills spaces; otherwise accepted data writes land at AC.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (state == S_CLEAR)  mem[cnt[4:0]] <= 8'h20;
            else if (wr_ok && cap_rs) mem[ac] <= cap_data;
        end
    end

    // Side read port for the display, one cycle latency, live during clear.
    always_ff @(posedge CLK) begin
        if (RESET) RD_CHAR <= 8'h00;
        else       RD_CHAR <= mem[{RD_LINE, RD_COL}];
    end

endmodule

// File: tb/tb_lcd_char_receiver.sv
// tb_lcd_char_receiver: directed bus sequences with a scoreboard of expected
// read data, status, flags and busy durations.
module tb_lcd_char_receiver;

    localparam int BC = 6;   // long enough that a back-to-back access lands while busy

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       LCD_E = 1'b0, LCD_RS = 1'b0, LCD_RW = 1'b0;
    logic [7:0] LCD_DATA = 8'h00;
    logic       RD_LINE = 1'b0;
    logic [3:0] RD_COL = 4'h0;
    logic [7:0] LCD_DOUT, RD_CHAR;
    logic       LCD_DOE, BUSY, OVERRUN, DISP_ON, LINES2;

    lcd_char_receiver #(.BUSY_CYCLES(BC)) dut (
        .CLK(CLK), .RESET(RESET), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
        .LCD_DATA(LCD_DATA), .LCD_DOUT(LCD_DOUT), .LCD_DOE(LCD_DOE), .BUSY(BUSY),
        .OVERRUN(OVERRUN), .DISP_ON(DISP_ON), .LINES2(LINES2),
        .RD_LINE(RD_LINE), .RD_COL(RD_COL), .RD_CHAR(RD_CHAR)
    );

    always #5 CLK = ~CLK;

    typedef struct { string tag; logic [15:0] val; } exp_t;
    exp_t sb[$];
    int total = 0;
    int bad = 0;

    task automatic push(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [15:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty obs=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s obs=%h exp=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // One bus access: E high for two cycles, low for two cycles.
    task automatic access(input logic rs, input logic rw, input logic [7:0] d);
        LCD_RS = rs; LCD_RW = rw; LCD_DATA = d; LCD_E = 1'b1;
        @(negedge CLK); @(negedge CLK);
        if (rw) pop_chk({7'h0, LCD_DOE, LCD_DOUT});
        LCD_E = 1'b0;
        @(negedge CLK); @(negedge CLK);
        if (rw) pop_chk({15'h0, LCD_DOE});
    endtask

    task automatic wr(input logic rs, input logic [7:0] d);
        access(rs, 1'b0, d);
    endtask

    task automatic rd(input logic rs, input logic [7:0] exp, input string tag);
        push(tag, {7'h0, 1'b1, exp});
        push({tag, "_doe_off"}, 16'h0);
        access(rs, 1'b1, 8'h00);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY === 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (BUSY !== 1'b0) begin
            push("idle_timeout", 16'h0);
            pop_chk({15'h0, BUSY});
        end
    endtask

    task automatic wri(input logic rs, input logic [7:0] d);
        wait_idle();
        wr(rs, d);
        wait_idle();
    endtask

    task automatic rdc(input logic line, input logic [3:0] col, input logic [7:0] exp, input string tag);
        push(tag, {8'h0, exp});
        RD_LINE = line; RD_COL = col;
        @(negedge CLK);
        pop_chk({8'h0, RD_CHAR});
    endtask

    task automatic busy_len(input string tag);
        int n = 0;
        push(tag, 16'd32);
        while (BUSY === 1'b1 && n < 100) begin
            n++;
            @(negedge CLK);
        end
        pop_chk(16'(n));
    endtask

    task automatic all_spaces(input string tag);
        for (int i = 0; i < 32; i++) rdc(i[4], i[3:0], 8'h20, tag);
    endtask

    task automatic flag(input string tag, input logic obs, input logic exp);
        push(tag, {15'h0, exp});
        pop_chk({15'h0, obs});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) @(negedge CLK);
        push("rst_flags", 16'h0001);
        pop_chk({11'h0, DISP_ON, LINES2, OVERRUN, LCD_DOE, BUSY});
        push("rst_dout", 16'h0);
        pop_chk({8'h0, LCD_DOUT});
        push("rst_rdchar", 16'h0);
        pop_chk({8'h0, RD_CHAR});
        RESET = 1'b0;
        busy_len("rst_busy_len");
        all_spaces("rst_space");
        rd(1'b0, 8'h00, "rst_status");

        // init and first data
        wri(1'b0, 8'h38); wri(1'b0, 8'h0C); wri(1'b0, 8'h06); wri(1'b0, 8'h80);
        wri(1'b1, 8'h31); wri(1'b1, 8'h32);
        flag("init_lines2", LINES2, 1'b1);
        flag("init_disp_on", DISP_ON, 1'b1);
        rdc(1'b0, 4'd0, 8'h31, "init_rd00");
        rdc(1'b0, 4'd1, 8'h32, "init_rd01");
        rd(1'b0, 8'h02, "init_status");

        // 2-line wrap
        wri(1'b0, 8'h8F); wri(1'b1, 8'h41); wri(1'b1, 8'h42);
        rdc(1'b0, 4'd15, 8'h41, "wrap2_rd0f");
        rdc(1'b1, 4'd0, 8'h42, "wrap2_rd10");
        rd(1'b0, 8'h41, "wrap2_status");

        // 1-line wrap
        wri(1'b0, 8'h30);
        flag("wrap1_lines2", LINES2, 1'b0);
        wri(1'b0, 8'h8F); wri(1'b1, 8'h41); wri(1'b1, 8'h42);
        rdc(1'b0, 4'd15, 8'h41, "wrap1_rd0f");
        rdc(1'b0, 4'd0, 8'h42, "wrap1_rd00");
        rd(1'b0, 8'h01, "wrap1_status");

        // overrun: data write lands inside the exec busy window
        wait_idle();
        wr(1'b0, 8'h80);
        wr(1'b1, 8'h55);
        wait_idle();
        flag("ovr_set", OVERRUN, 1'b1);
        rdc(1'b0, 4'd0, 8'h42, "ovr_ddram_kept");
        rd(1'b0, 8'h00, "ovr_status");
        flag("ovr_cleared", OVERRUN, 1'b0);

        // decrement read, then clear
        wri(1'b0, 8'h38); wri(1'b0, 8'h04); wri(1'b0, 8'h80);
        rd(1'b1, 8'h42, "dec_data_read");
        wait_idle();
        rd(1'b0, 8'h4F, "dec_status");
        wr(1'b0, 8'h01);
        busy_len("clr_busy_len");
        all_spaces("clr_space");
        rd(1'b0, 8'h00, "clr_status");
        wri(1'b1, 8'h77);
        rd(1'b0, 8'h01, "clr_inc_status");

        // reset in the middle of a clear restarts the full sweep
        wri(1'b0, 8'hCF); wri(1'b1, 8'h5A);
        wr(1'b0, 8'h01);
        rdc(1'b1, 4'd15, 8'h5A, "midclr_unfilled");
        rdc(1'b0, 4'd0, 8'h20, "midclr_filled");
        repeat (8) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        busy_len("midclr_busy_len");
        flag("midclr_disp_on", DISP_ON, 1'b0);
        flag("midclr_lines2", LINES2, 1'b0);
        rdc(1'b1, 4'd15, 8'h20, "midclr_rd1f");
        rd(1'b0, 8'h00, "midclr_status");

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover obs=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
